// File: rtl/conv_frame_sequencer.sv
// Purpose: sequences 3x3 same-padding conv frames (SOF, column-major pixel reads, padding flush, window drain) per channel.
// Latency: lb_sof one cycle after an accepted start; first read the cycle after lb_sof; lb_input_valid trails mem_rd_en by 1.
// Backpressure: stall gates mem_rd_en/lb_flush in the same cycle and freezes the pixel/flush counters.
// Ports: clk/rst (sync, active-high); start/stall control in; mem_rd_en/mem_addr read port out;
//        lb_sof/lb_input_valid/lb_flush to line buffer ctrl, lb_output_valid back; cur_ch/seq_busy/done status out.
module conv_frame_sequencer #(
  parameter int unsigned input_y   = 3,
  parameter int unsigned input_x   = 3,
  parameter int unsigned num_ch    = 1,
  parameter int unsigned addr_w    = 16,
  parameter int unsigned base_addr = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stall,
  output logic              mem_rd_en,
  output logic [addr_w-1:0] mem_addr,
  output logic              lb_sof,
  output logic              lb_input_valid,
  output logic              lb_flush,
  input  logic              lb_output_valid,
  output logic [7:0]        cur_ch,
  output logic              seq_busy,
  output logic              done
);

  localparam logic [15:0] NPIX   = 16'(input_x * input_y);
  localparam logic [7:0]  YLAST  = 8'(input_y - 1);
  localparam logic [7:0]  CHLAST = 8'(num_ch - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SOF, S_STREAM, S_FLUSH, S_DRAIN, S_NEXT, S_FIN
  } state_t;

  state_t              state_q, state_d;
  logic [15:0]         p_q, p_d;
  logic [15:0]         w_q, w_d;
  logic [7:0]          f_q, f_d;
  logic [7:0]          cur_ch_q, cur_ch_d;
  logic [addr_w-1:0]   addr_q, addr_d;
  logic                sof_q, sof_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                ivld_q;
  logic                rd_go, fl_go;
  logic [addr_w-1:0]   chan_base;

  // Stall is applied combinationally so a stalled cycle never carries a read or a flush beat.
  assign rd_go = (state_q == S_STREAM) && !stall;
  assign fl_go = (state_q == S_FLUSH) && !stall;

  // First address of the current channel; wrap at addr_w bits is intentional.
  assign chan_base = addr_w'(base_addr + 32'(cur_ch_q) * 32'(NPIX));

  always_comb begin
    state_d  = state_q;
    p_d      = p_q;
    f_d      = f_q;
    w_d      = w_q;
    cur_ch_d = cur_ch_q;
    addr_d   = addr_q;

    // Window count saturates so stray pulses after the last window cannot overrun.
    if ((state_q == S_STREAM || state_q == S_FLUSH || state_q == S_DRAIN) &&
        lb_output_valid && (w_q < NPIX)) begin
      w_d = w_q + 16'd1;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_SOF;
          cur_ch_d = 8'd0;
        end
      end
      S_SOF: begin
        p_d     = 16'd0;
        f_d     = 8'd0;
        w_d     = 16'd0;
        addr_d  = chan_base;
        state_d = S_STREAM;
      end
      S_STREAM: begin
        if (rd_go) begin
          p_d    = p_q + 16'd1;
          addr_d = addr_q + addr_w'(1);
          if (p_q == NPIX - 16'd1) state_d = S_FLUSH;
        end
      end
      S_FLUSH: begin
        if (fl_go) begin
          f_d = f_q + 8'd1;
          if (f_q == YLAST) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (w_q == NPIX) state_d = S_NEXT;
      end
      S_NEXT: begin
        if (cur_ch_q < CHLAST) begin
          cur_ch_d = cur_ch_q + 8'd1;
          state_d  = S_SOF;
        end else begin
          state_d = S_FIN;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Status outputs are registered from the next state so they line up with the state they describe.
    sof_d  = (state_d == S_SOF);
    busy_d = (state_d != S_IDLE) && (state_d != S_FIN);
    done_d = (state_d == S_FIN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      p_q      <= '0;
      f_q      <= '0;
      w_q      <= '0;
      cur_ch_q <= '0;
      addr_q   <= '0;
      sof_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ivld_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      p_q      <= p_d;
      f_q      <= f_d;
      w_q      <= w_d;
      cur_ch_q <= cur_ch_d;
      addr_q   <= addr_d;
      sof_q    <= sof_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      ivld_q   <= rd_go;  // memory has one cycle of read latency
    end
  end

  assign mem_rd_en      = rd_go;
  assign mem_addr       = addr_q;
  assign lb_sof         = sof_q;
  assign lb_input_valid = ivld_q;
  assign lb_flush       = fl_go;
  assign cur_ch         = cur_ch_q;
  assign seq_busy       = busy_q;
  assign done           = done_q;

endmodule

// File: tb/tb_conv_frame_sequencer.sv
// Purpose: directed self-checking bench for conv_frame_sequencer (3x3 map, 2 channels, base 0x100).
// Latency: inputs are applied 1 time unit after each rising edge and outputs are sampled 1 unit later.
// Backpressure: stall is driven from directed conditions on observed addresses / flush beats.
module tb_conv_frame_sequencer;

  logic        clk = 1'b0;
  logic        rst, start, stall, lb_output_valid;
  logic        mem_rd_en, lb_sof, lb_input_valid, lb_flush, seq_busy, done;
  logic [15:0] mem_addr;
  logic [7:0]  cur_ch;

  int checks = 0;
  int failures = 0;

  // Bench-side line buffer model and run statistics
  int beats, wins, extra, sof_cnt, reads, ivalids, flushes, ch_flush, done_cnt;
  logic done_seen;
  logic [15:0] addr_log[$];

  always #5 clk = ~clk;

  conv_frame_sequencer #(
    .input_y(3), .input_x(3), .num_ch(2), .addr_w(16), .base_addr(32'h100)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .stall(stall),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .lb_sof(lb_sof),
    .lb_input_valid(lb_input_valid), .lb_flush(lb_flush),
    .lb_output_valid(lb_output_valid), .cur_ch(cur_ch),
    .seq_busy(seq_busy), .done(done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_stats();
    beats = 0; wins = 0; extra = 0; sof_cnt = 0; reads = 0; ivalids = 0;
    flushes = 0; ch_flush = 0; done_cnt = 0; done_seen = 1'b0;
    addr_log.delete();
    lb_output_valid = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Apply this cycle's inputs, let outputs settle, then record them and run the window model.
  // A 3x3 same-padding window becomes available once 4 beats past it have arrived.
  task automatic tick(input logic st, input logic sa);
    stall = st;
    start = sa;
    #1;
    if (lb_sof) begin
      sof_cnt++; beats = 0; wins = 0; ch_flush = 0;
    end
    if (extra > 0) begin
      lb_output_valid = 1'b1; extra--;
    end else if (beats - 3 > wins) begin
      lb_output_valid = 1'b1; wins++;
    end else begin
      lb_output_valid = 1'b0;
    end
    beats += int'(lb_input_valid) + int'(lb_flush);
    if (mem_rd_en) begin
      reads++; addr_log.push_back(mem_addr);
    end
    if (lb_input_valid) ivalids++;
    if (lb_flush) begin
      flushes++; ch_flush++;
    end
    if (done) begin
      done_cnt++; done_seen = 1'b1;
    end
  endtask

  task automatic run_to_done();
    for (int i = 0; i < 300; i++) begin
      tick(1'b0, 1'b0);
      if (done_seen) break;
      step();
    end
  endtask

  initial begin
    logic [7:0]  ch_at_sof2;
    logic [2:0]  iv_pat;
    int          st_left, fl_left, stall_reads, stall_flushes, n104;
    logic        st_used, fl_used, rst_hit, injected, st, sa;

    rst = 1'b1; start = 1'b0; stall = 1'b0; lb_output_valid = 1'b0;
    clear_stats();
    step(); step();
    tick(1'b0, 1'b0);
    chk("reset_outs", 32'({mem_rd_en, lb_sof, lb_input_valid, lb_flush, seq_busy, done, cur_ch, mem_addr}), 0);
    rst = 1'b0;
    step();

    // ---- Run 1: no stall, cycle-exact timing of channel 0, then channel 1 to done
    clear_stats();
    tick(1'b0, 1'b1); step();
    for (int c = 1; c <= 14; c++) begin
      logic [3:0] exp_v;
      tick(1'b0, 1'b0);
      exp_v = {c == 1, c >= 2 && c <= 10, c >= 3 && c <= 11, c >= 11 && c <= 13};
      chk($sformatf("t1_strobes_c%0d", c), 32'({lb_sof, mem_rd_en, lb_input_valid, lb_flush}), 32'(exp_v));
      if (c >= 2 && c <= 10) chk($sformatf("t1_addr_c%0d", c), 32'(mem_addr), 32'h100 + c - 2);
      if (c == 1) chk("t1_busy_at_sof", 32'(seq_busy), 1);
      step();
    end
    ch_at_sof2 = 8'hff;
    for (int i = 0; i < 300; i++) begin
      tick(1'b0, 1'b0);
      if (lb_sof && sof_cnt == 2) ch_at_sof2 = cur_ch;
      if (done_seen) break;
      step();
    end
    chk("t1_done_seen", 32'(done_seen), 1);
    chk("t1_done_busy", 32'(seq_busy), 0);
    chk("t1_done_cur_ch", 32'(cur_ch), 1);
    chk("t1_sofs_at_done", sof_cnt, 2);
    chk("t1_ch1_wins_at_done", wins, 9);
    chk("t1_cur_ch_in_ch1", 32'(ch_at_sof2), 1);
    chk("t1_reads", reads, 18);
    chk("t1_ch1_first_addr", 32'(addr_log[9]), 32'h109);
    chk("t1_ch1_last_addr", 32'(addr_log[17]), 32'h111);
    step();
    for (int i = 0; i < 5; i++) begin
      tick(1'b0, 1'b0); step();
    end
    chk("t1_done_pulses", done_cnt, 1);
    chk("t1_ivalids", ivalids, 18);
    chk("t1_flushes", flushes, 6);

    // ---- Run 2: stall 3 cycles at address 4, stall 2 cycles after the first flush beat
    clear_stats();
    tick(1'b0, 1'b1); step();
    st_left = 0; fl_left = 0; st_used = 0; fl_used = 0;
    stall_reads = 0; stall_flushes = 0; iv_pat = '0;
    for (int i = 0; i < 300; i++) begin
      if (!st_used && seq_busy && sof_cnt == 1 && mem_addr == 16'h104) begin
        st_left = 3; st_used = 1'b1;
      end
      if (!fl_used && sof_cnt == 1 && ch_flush == 1) begin
        fl_left = 2; fl_used = 1'b1;
      end
      tick((st_left > 0) || (fl_left > 0), 1'b0);
      if (st_left > 0) begin
        stall_reads += int'(mem_rd_en);
        iv_pat = {iv_pat[1:0], lb_input_valid};
        st_left--;
      end
      if (fl_left > 0) begin
        stall_flushes += int'(lb_flush);
        fl_left--;
      end
      if (done_seen) break;
      step();
    end
    n104 = 0;
    foreach (addr_log[k]) if (addr_log[k] == 16'h104) n104++;
    chk("t2_stalls_applied", 32'({st_used, fl_used}), 3);
    chk("t2_done_seen", 32'(done_seen), 1);
    chk("t2_reads_in_stall", stall_reads, 0);
    chk("t2_ivalid_in_stall", 32'(iv_pat), 32'b100);
    chk("t2_flush_in_stall", stall_flushes, 0);
    chk("t2_addr4_count", n104, 1);
    chk("t2_addr_after4", 32'(addr_log[5]), 32'h105);
    chk("t2_reads", reads, 18);
    chk("t2_ivalids", ivalids, 18);
    chk("t2_flushes", flushes, 6);
    step();

    // ---- Run 3: reset while mem_addr shows pixel 5, then clean restart
    clear_stats();
    tick(1'b0, 1'b1); step();
    rst_hit = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (seq_busy && mem_addr == 16'h105) begin
        rst = 1'b1; rst_hit = 1'b1;
      end
      tick(1'b0, 1'b0);
      step();
      if (rst_hit) break;
    end
    rst = 1'b0;
    tick(1'b0, 1'b0);
    chk("t3_rst_hit", 32'(rst_hit), 1);
    chk("t3_rst_outs", 32'({mem_rd_en, lb_sof, lb_input_valid, lb_flush, seq_busy, done, cur_ch, mem_addr}), 0);
    step();
    clear_stats();
    tick(1'b0, 1'b1); step();
    tick(1'b0, 1'b0);
    chk("t3_restart_sof", 32'(lb_sof), 1);
    step();
    tick(1'b0, 1'b0);
    chk("t3_restart_addr", 32'({mem_rd_en, mem_addr}), 32'h1_0100);
    step();
    run_to_done();
    chk("t3_done_seen", 32'(done_seen), 1);
    step();

    // ---- Run 4: start pulse and two extra windows during channel-1 drain
    clear_stats();
    tick(1'b0, 1'b1); step();
    injected = 1'b0;
    for (int i = 0; i < 300; i++) begin
      sa = 1'b0;
      if (!injected && sof_cnt == 2 && wins == 9 && ch_flush == 3) begin
        sa = 1'b1; extra = 2; injected = 1'b1;
      end
      st = 1'b0;
      tick(st, sa);
      if (done_seen) break;
      step();
    end
    chk("t4_injected", 32'(injected), 1);
    chk("t4_done_seen", 32'(done_seen), 1);
    step();
    for (int i = 0; i < 10; i++) begin
      tick(1'b0, 1'b0); step();
    end
    chk("t4_done_pulses", done_cnt, 1);
    chk("t4_no_rerun_sofs", sof_cnt, 2);
    chk("t4_reads", reads, 18);
    chk("t4_idle_busy", 32'(seq_busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
